// File: rtl/ibex_data_mem_responder_if.sv
// Core data bus (req/gnt/rvalid/err) between the load/store unit and a
// memory responder. The master drives requests and the slave answers them.
interface ibex_data_mem_responder_if;
    logic        data_req_i;
    logic        data_gnt_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic        data_err_o;
    logic [31:0] data_rdata_o;

    modport master (
        output data_req_i,
        output data_addr_i,
        output data_we_i,
        output data_be_i,
        output data_wdata_i,
        input  data_gnt_o,
        input  data_rvalid_o,
        input  data_err_o,
        input  data_rdata_o
    );

    modport slave (
        input  data_req_i,
        input  data_addr_i,
        input  data_we_i,
        input  data_be_i,
        input  data_wdata_i,
        output data_gnt_o,
        output data_rvalid_o,
        output data_err_o,
        output data_rdata_o
    );
endinterface

// File: rtl/ibex_data_mem_responder.sv
// Memory-side responder for the core data bus: word-addressed RAM with
// byte-enabled writes, fixed-latency in-order responses and an error
// response for addresses outside the RAM window.
module ibex_data_mem_responder #(
    parameter int          MemWords    = 1024,
    parameter logic [31:0] BaseAddr    = 32'h0010_0000,
    parameter int          RespLatency = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    ibex_data_mem_responder_if.slave    bus,
    input  logic                        stall_i,
    output logic [2:0]                  outstanding_o
);

    localparam int          IdxW     = $clog2(MemWords);
    localparam logic [31:0] MemBytes = 32'(MemWords * 4);
    localparam int          Last     = RespLatency - 1;

    logic                gnt_s;
    logic [31:0]         offset_s;
    logic                in_range_s;
    logic [IdxW-1:0]     word_idx_s;
    logic                wr_en_s;
    logic                load_err_s;
    logic [31:0]         load_rdata_s;
    logic                retire_s;
    logic                unused_addr_s;

    logic [31:0]         mem_r [MemWords];
    logic                valid_r [RespLatency];
    logic                err_r   [RespLatency];
    logic [31:0]         rdata_r [RespLatency];
    logic [2:0]          outstanding_r;

    // Grant is combinational; the pipeline depth itself bounds in-flight requests.
    assign gnt_s = bus.data_req_i & ~stall_i;

    // Subtracting first keeps the window check safe against 32-bit wrap at the top.
    assign offset_s   = bus.data_addr_i - BaseAddr;
    assign in_range_s = (bus.data_addr_i >= BaseAddr) && (offset_s < MemBytes);
    assign word_idx_s = offset_s[IdxW+1:2];
    assign wr_en_s    = gnt_s & in_range_s & bus.data_we_i;

    // Byte-lane bits and offset bits above the RAM window carry no information.
    assign unused_addr_s = ^{offset_s[1:0], offset_s[31:IdxW+2]};

    // Commit byte-enabled writes to the RAM array on the grant edge.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.data_be_i[n]) begin
                    mem_r[word_idx_s][n*8 +: 8] <= bus.data_wdata_i[n*8 +: 8];
                end
            end
        end
    end

    // Build the response entering stage 0: error for out-of-range, word for in-range reads, zero otherwise.
    always_comb begin
        load_err_s   = 1'b0;
        load_rdata_s = 32'h0000_0000;
        if (gnt_s && !in_range_s) begin
            load_err_s = 1'b1;
        end else if (gnt_s && !bus.data_we_i) begin
            load_rdata_s = mem_r[word_idx_s];
        end else begin
            load_err_s   = 1'b0;
            load_rdata_s = 32'h0000_0000;
        end
    end

    // Response shift register: stage 0 loads on grant, every stage advances each cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RespLatency; i++) begin
                valid_r[i] <= 1'b0;
                err_r[i]   <= 1'b0;
                rdata_r[i] <= 32'h0000_0000;
            end
        end else begin
            valid_r[0] <= gnt_s;
            err_r[0]   <= load_err_s;
            rdata_r[0] <= load_rdata_s;
            for (int i = 1; i < RespLatency; i++) begin
                valid_r[i] <= valid_r[i-1];
                err_r[i]   <= err_r[i-1];
                rdata_r[i] <= rdata_r[i-1];
            end
        end
    end

    assign retire_s = valid_r[Last];

    // Track granted-but-unanswered requests; a grant and a retirement together cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_r <= 3'd0;
        end else begin
            case ({gnt_s, retire_s})
                2'b10:   outstanding_r <= outstanding_r + 3'd1;
                2'b01:   outstanding_r <= outstanding_r - 3'd1;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    assign bus.data_gnt_o    = gnt_s;
    assign bus.data_rvalid_o = valid_r[Last];
    assign bus.data_err_o    = err_r[Last];
    assign bus.data_rdata_o  = rdata_r[Last];
    assign outstanding_o     = outstanding_r;

endmodule

// File: tb/tb_ibex_data_mem_responder.sv
// Scoreboard bench: three responders (latency 1, 3, 4) share one stimulus
// stream; each has its own expected-response queue drained by a monitor.
module tb_ibex_data_mem_responder;

    localparam logic [31:0] BASE   = 32'h0010_0000;
    localparam logic [31:0] OOR_HI = 32'h0010_1000;
    localparam logic [31:0] OOR_LO = 32'h000F_FFFC;

    typedef struct packed {
        logic [31:0] due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall = 1'b0;

    logic        gt [3];
    logic        rv [3];
    logic        er [3];
    logic [31:0] rd [3];
    logic [2:0]  os [3];

    exp_t sbq [3][$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d (lat %0d) cycle %0d: got %h expected %h", name, k, lat_of(k), cyc, act, exp);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
        ibex_data_mem_responder_if bus ();
        logic [2:0] outstanding;

        assign bus.data_req_i   = req;
        assign bus.data_addr_i  = addr;
        assign bus.data_we_i    = we;
        assign bus.data_be_i    = be;
        assign bus.data_wdata_i = wdata;

        ibex_data_mem_responder #(
            .MemWords    (1024),
            .BaseAddr    (BASE),
            .RespLatency (L)
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_ni),
            .bus           (bus),
            .stall_i       (stall),
            .outstanding_o (outstanding)
        );

        assign gt[k] = bus.data_gnt_o;
        assign rv[k] = bus.data_rvalid_o;
        assign er[k] = bus.data_err_o;
        assign rd[k] = bus.data_rdata_o;
        assign os[k] = outstanding;

        // Monitor: pop and compare whenever a response appears; flag late or spurious ones.
        always @(negedge clk) begin
            exp_t e;
            if (rv[k]) begin
                if (sbq[k].size() == 0) begin
                    check("spurious_rvalid", k, {31'd0, rv[k]}, 32'd0);
                end else begin
                    e = sbq[k].pop_front();
                    check("rvalid_cycle", k, 32'(cyc), e.due);
                    check("err", k, {31'd0, er[k]}, {31'd0, e.err});
                    check("rdata", k, rd[k], e.rdata);
                end
            end else if (sbq[k].size() != 0 && sbq[k][0].due <= 32'(cyc)) begin
                check("missing_rvalid", k, {31'd0, rv[k]}, 32'd1);
                e = sbq[k].pop_front();
            end else begin
                check("idle_outputs", k, rd[k] | {31'd0, er[k]}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] wd,
                         input logic st, input logic exp_g, input logic exp_e, input logic [31:0] exp_r);
        exp_t e;
        @(posedge clk);
        #1;
        req = 1'b1; addr = a; we = w; be = b; wdata = wd; stall = st;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("gnt", k, {31'd0, gt[k]}, {31'd0, exp_g});
            if (exp_g) begin
                e.due   = 32'(cyc + lat_of(k));
                e.err   = exp_e;
                e.rdata = exp_r;
                sbq[k].push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            req = 1'b0; we = 1'b0; be = 4'h0; stall = 1'b0;
        end
    endtask

    task automatic check_outstanding(input string name, input logic [2:0] e0, input logic [2:0] e1, input logic [2:0] e2);
        check(name, 0, {29'd0, os[0]}, {29'd0, e0});
        check(name, 1, {29'd0, os[1]}, {29'd0, e1});
        check(name, 2, {29'd0, os[2]}, {29'd0, e2});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        for (int k = 0; k < 3; k++) begin
            check("reset_rvalid", k, {31'd0, rv[k]}, 32'd0);
            check("reset_rdata", k, rd[k] | {31'd0, er[k]}, 32'd0);
        end
        check_outstanding("reset_outstanding", 3'd0, 3'd0, 3'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Write then read back-to-back, plus a read with no byte enables
        issue(BASE + 32'd8, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'h0);
        issue(BASE + 32'd8, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        issue(BASE + 32'd8, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        idle(6);
        check_outstanding("drain1", 3'd0, 3'd0, 3'd0);

        // Byte-enabled merge and a be=0 no-op write
        issue(BASE + 32'd12, 1'b1, 4'hF,    32'h1122_3344, 1'b0, 1'b1, 1'b0, 32'h0);
        issue(BASE + 32'd12, 1'b1, 4'b0110, 32'hAABB_CCDD, 1'b0, 1'b1, 1'b0, 32'h0);
        issue(BASE + 32'd12, 1'b0, 4'hF,    32'h0,         1'b0, 1'b1, 1'b0, 32'h11BB_CC44);
        issue(BASE + 32'd12, 1'b1, 4'h0,    32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0);
        issue(BASE + 32'd12, 1'b0, 4'hF,    32'h0,         1'b0, 1'b1, 1'b0, 32'h11BB_CC44);
        idle(6);

        // Out-of-range accesses on both sides of the window; word 0 must survive
        issue(BASE,   1'b1, 4'hF, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, 32'h0);
        issue(OOR_LO, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0);
        issue(OOR_HI, 1'b1, 4'hF, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 32'h0);
        issue(BASE,   1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0BAD_F00D);
        idle(6);

        // Split access pattern: write then read the same word on consecutive cycles
        issue(BASE + 32'd16, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 32'h0);
        issue(BASE + 32'd16, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 1'b0, 32'hCAFE_F00D);
        idle(1);
        check_outstanding("peak_outstanding", 3'd1, 3'd2, 3'd2);
        idle(6);
        check_outstanding("drain2", 3'd0, 3'd0, 3'd0);

        // Stall blocks grants for 5 cycles while an earlier response still completes
        issue(BASE + 32'd16, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D);
        repeat (5) issue(BASE + 32'd8, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(BASE + 32'd8, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        idle(6);
        check_outstanding("drain3", 3'd0, 3'd0, 3'd0);

        // Reset two cycles after a read grant drops the in-flight responses
        issue(BASE + 32'd8, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        idle(1);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        for (int k = 0; k < 3; k++) sbq[k].delete();
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_rvalid", k, {31'd0, rv[k]}, 32'd0);
        end
        check_outstanding("rst_outstanding", 3'd0, 3'd0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        issue(BASE + 32'd8, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        idle(6);
        check_outstanding("drain4", 3'd0, 3'd0, 3'd0);

        for (int k = 0; k < 3; k++) begin
            check("queue_empty", k, 32'(sbq[k].size()), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_data_mem_responder.md
Name: ibex_data_mem_responder

Overview:
- Memory-side responder for the core data bus (req/gnt/rvalid/err protocol): single-port word-addressed RAM with byte-enabled writes, fixed-latency in-order responses, and out-of-range error signalling.
- Sits behind the load/store unit in the simple-system testbench and synthesis harness.
- Supports the back-to-back and pipelined request patterns the LSU issues for misaligned split accesses.

Parameters:
- MemWords, 1024, RAM depth in 32-bit words (power of two, >= 4)
- BaseAddr, 32'h0010_0000, byte address of word 0 (aligned to MemWords*4)
- RespLatency, 1, cycles from grant to rvalid (legal range 1..4)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_req_i  in  1  request valid
- data_gnt_o  out  1  request accepted this cycle
- data_addr_i  in  32  byte address; bits [1:0] ignored
- data_we_i  in  1  1 = write, 0 = read
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data, already lane-aligned
- data_rvalid_o  out  1  response valid
- data_err_o  out  1  bus error, qualified by rvalid
- data_rdata_o  out  32  read data, qualified by rvalid
- stall_i  in  1  forces grant low (verification back-pressure)
- outstanding_o  out  3  number of granted, unanswered requests

Behaviour:
- Clock and reset: clock clk_i; reset rst_ni, asynchronous, active-low.
- Reset values:
  - data_rvalid_o=0, data_err_o=0, data_rdata_o=0, outstanding_o=0.
  - All response pipeline stages are invalid.
  - RAM contents are not reset.
- Grant:
  - data_gnt_o = data_req_i & ~stall_i. Purely combinational; no dependence on outstanding count.
  - The fixed-latency pipeline bounds outstanding requests to RespLatency.
- Hit check at grant: in_range = (addr >= BaseAddr) && (addr < BaseAddr + MemWords*4). Word index = (addr - BaseAddr) >> 2.
- Write, granted and in range:
  - RAM updated on the grant clock edge, only for lanes where data_be_i[n]=1.
  - be=4'b0000 is a legal no-op with an error-free response.
- Read, granted and in range:
  - The RAM word is sampled at grant; the full 32 bits are returned regardless of be.
  - A read granted the cycle after a write to the same word returns the new data.
- Out of range:
  - No RAM access.
  - Response carries err=1 and rdata=0, for both reads and writes.
- Response pipeline:
  - RespLatency-deep shift register. Each stage holds {valid, err, rdata}; rdata is forced to 0 for writes.
  - Stage 0 is loaded on grant and shifts every cycle.
  - The last stage drives data_rvalid_o, data_err_o and data_rdata_o.
  - No rvalid back-pressure: the requester must always accept responses.
  - With no response, err=0 and rdata=0.
- Ordering and timing:
  - Responses return strictly in grant order.
  - Rvalid is asserted exactly RespLatency cycles after the gnt cycle.
  - One grant per cycle maximum; consecutive-cycle grants yield consecutive-cycle rvalids.
- Simultaneous events: grant and rvalid in the same cycle are legal. The new request enters stage 0 while the oldest retires.
- outstanding_o is a registered count:
  - increment on grant, decrement on rvalid, unchanged when both occur in the same cycle;
  - never exceeds RespLatency.
- Stall: stall_i asserted mid-stream blocks new grants only; in-flight responses still complete on schedule.
- Reset mid-operation:
  - Asynchronously clears all in-flight responses and the count. Dropped responses are never emitted.
  - Writes already committed on earlier edges persist.
- Unsupported:
  - Address bits [1:0] are ignored (the requester always word-aligns).
  - X on data_req_i is not handled.

Test Plan:
- Write/read, RespLatency=1: write 32'hDEADBEEF, be=4'hF to BaseAddr+8, then read it -> gnt in the request cycles; rvalid one cycle after each gnt; read returns 32'hDEADBEEF, err=0.
- Byte enables: preload 32'h11223344; write 32'hAABBCCDD with be=4'b0110, then read -> 32'h11BBCC44; be=0 write leaves the word unchanged with err=0.
- Out of range: read BaseAddr-4 and write BaseAddr+MemWords*4 -> both responses err=1, rdata=0; the RAM word at index 0 is unchanged.
- Back-to-back split, RespLatency=3: grants on cycles t, t+1 (write word A, then read word A) -> rvalids at t+3 and t+4; the read returns the written data; outstanding_o peaks at 2.
- Stall: hold req with stall_i=1 for 5 cycles then release -> no gnt during the stall; gnt on the release cycle; rvalid RespLatency cycles later; an earlier in-flight response completes during the stall.
- Reset mid-flight, RespLatency=4: grant a read, assert rst_ni=0 two cycles later -> rvalid never asserted for it; outputs 0 immediately; after reset the first new read responds normally.
